// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, type codes and the packed control word
// consumed by the decoder, ALU-control and register-file blocks.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int CW_W = 23;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] T_ILLEGAL = 4'd0;
    localparam logic [3:0] T_LOAD    = 4'd1;
    localparam logic [3:0] T_OPIMM   = 4'd2;
    localparam logic [3:0] T_STORE   = 4'd3;
    localparam logic [3:0] T_OP      = 4'd4;
    localparam logic [3:0] T_LUI     = 4'd5;
    localparam logic [3:0] T_AUIPC   = 4'd6;
    localparam logic [3:0] T_BRANCH  = 4'd7;
    localparam logic [3:0] T_JALR    = 4'd8;
    localparam logic [3:0] T_JAL     = 4'd9;

    localparam int CW_TYPE_LSB = 0;
    localparam int CW_FUN3_LSB = 4;
    localparam int CW_FUN7_BIT = 7;
    localparam int CW_RD_LSB   = 8;
    localparam int CW_RS1_LSB  = 13;
    localparam int CW_RS2_LSB  = 18;

    // Field order is MSB first so the struct overlays the flat cword bit ranges.
    typedef struct packed {
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [4:0] rd;
        logic       fun7;
        logic [2:0] fun3;
        logic [3:0] itype;
    } cword_t;

    function automatic logic isShiftImm(input logic [2:0] fun3);
        return (fun3 == 3'b001) || (fun3 == 3'b101);
    endfunction

endpackage

// File: rtl/instr_dec_comb.sv
// Purely combinational RV32I decode of one instruction word into a control word
// plus an unsupported-instruction flag.
module instr_dec_comb
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] inst_i,
    output cword_t          cword_o,
    output logic            illegal_o
);

    logic [3:0] itype;
    logic [2:0] fun3;
    logic [6:0] funct7;
    logic       useRd;
    logic       useRs1;
    logic       useRs2;
    logic       useFun7;

    assign fun3   = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        itype = T_ILLEGAL;
        case (inst_i[6:0])
            OPC_LOAD:   itype = T_LOAD;
            OPC_OPIMM:  itype = T_OPIMM;
            OPC_STORE:  itype = T_STORE;
            OPC_OP:     itype = T_OP;
            OPC_LUI:    itype = T_LUI;
            OPC_AUIPC:  itype = T_AUIPC;
            OPC_BRANCH: itype = T_BRANCH;
            OPC_JALR:   itype = T_JALR;
            OPC_JAL:    itype = T_JAL;
            default:    itype = T_ILLEGAL;
        endcase
    end

    // rs1 and fun3 are present in exactly the same formats, so they share a flag.
    always_comb begin
        useRd   = itype inside {T_LOAD, T_OPIMM, T_OP, T_LUI, T_AUIPC, T_JALR, T_JAL};
        useRs1  = itype inside {T_LOAD, T_OPIMM, T_STORE, T_OP, T_BRANCH, T_JALR};
        useRs2  = itype inside {T_STORE, T_OP, T_BRANCH};
        useFun7 = (itype == T_OP) || ((itype == T_OPIMM) && isShiftImm(fun3));
    end

    always_comb begin
        cword_o       = '0;
        cword_o.itype = itype;
        if (useRd) begin
            cword_o.rd = inst_i[11:7];
        end
        if (useRs1) begin
            cword_o.rs1  = inst_i[19:15];
            cword_o.fun3 = fun3;
        end
        if (useRs2) begin
            cword_o.rs2 = inst_i[24:20];
        end
        if (useFun7) begin
            cword_o.fun7 = inst_i[30];
        end
    end

    // Fields stay populated for reserved encodings of known types; only the flag is raised.
    always_comb begin
        illegal_o = 1'b0;
        case (itype)
            T_ILLEGAL: illegal_o = 1'b1;
            T_JALR:    illegal_o = (fun3 != 3'b000);
            T_BRANCH:  illegal_o = (fun3 == 3'b010) || (fun3 == 3'b011);
            T_LOAD:    illegal_o = (fun3 == 3'b011) || (fun3 == 3'b110) || (fun3 == 3'b111);
            T_STORE:   illegal_o = (fun3 > 3'b010);
            T_OP:      illegal_o = !((funct7 == 7'b0000000) ||
                                     ((funct7 == 7'b0100000) && ((fun3 == 3'b000) || (fun3 == 3'b101))));
            default:   illegal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// RV32I instruction decoder top: registers the combinational decode with a
// one-cycle latency and a valid flag that follows inst_valid.
module instr_decoder
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] inst,
    input  logic            inst_valid,
    output logic [CW_W-1:0] cword,
    output logic            cword_valid,
    output logic            illegal
);

    cword_t          decCword;
    logic            decIllegal;
    logic [CW_W-1:0] cword_d;
    logic [CW_W-1:0] cword_q;
    logic            illegal_d;
    logic            illegal_q;
    logic            valid_q;

    instr_dec_comb u_comb (
        .inst_i    (inst),
        .cword_o   (decCword),
        .illegal_o (decIllegal)
    );

    // Idle cycles keep the last decode visible; only the valid flag drops.
    always_comb begin
        cword_d   = cword_q;
        illegal_d = illegal_q;
        if (inst_valid) begin
            cword_d   = decCword;
            illegal_d = decIllegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cword_q   <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cword_q   <= cword_d;
            illegal_q <= illegal_d;
            valid_q   <= inst_valid;
        end
    end

    assign cword       = cword_q;
    assign illegal     = illegal_q;
    assign cword_valid = valid_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed RV32I vectors followed by random
// instructions compared against a table-driven reference decoder.
module tb_instr_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic [22:0] cword;
    logic        cword_valid;
    logic        illegal;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [22:0] expCword;
    logic        expIllegal;
    logic        expValid;

    logic [6:0] opcodeTable [9] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011,
                                    7'b0110111, 7'b0010111, 7'b1100011, 7'b1100111,
                                    7'b1101111};
    localparam logic [15:0] RD_SET  = 16'h0376;
    localparam logic [15:0] RS1_SET = 16'h019E;
    localparam logic [15:0] RS2_SET = 16'h0098;

    instr_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .cword       (cword),
        .cword_valid (cword_valid),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void refDecode(input logic [31:0] word, output logic [22:0] cw,
                                      output logic ill);
        int typ = 0;
        int f3, f7, rd, rs1, rs2, top7;
        for (int i = 0; i < 9; i++) begin
            if (word[6:0] == opcodeTable[i]) typ = i + 1;
        end
        f3   = RS1_SET[typ] ? int'(word[14:12]) : 0;
        rd   = RD_SET[typ]  ? int'(word[11:7])  : 0;
        rs1  = RS1_SET[typ] ? int'(word[19:15]) : 0;
        rs2  = RS2_SET[typ] ? int'(word[24:20]) : 0;
        top7 = int'(word[31:25]);
        f7   = ((typ == 4) || (typ == 2 && (f3 == 1 || f3 == 5))) ? int'(word[30]) : 0;
        cw   = 23'(rs2 * 262144 + rs1 * 8192 + rd * 256 + f7 * 128 + f3 * 16 + typ);
        case (typ)
            0:       ill = 1'b1;
            8:       ill = (f3 != 0);
            7:       ill = (f3 == 2 || f3 == 3);
            1:       ill = (f3 == 3 || f3 >= 6);
            3:       ill = (f3 > 2);
            4:       ill = !(top7 == 0 || (top7 == 32 && (f3 == 0 || f3 == 5)));
            default: ill = 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle, advances the reference state and compares all outputs.
    task automatic applyStimulus(input logic [31:0] instIn, input logic validIn,
                                 input logic rstIn);
        logic [22:0] refCw;
        logic        refIll;
        inst       = instIn;
        inst_valid = validIn;
        rst        = rstIn;
        refDecode(instIn, refCw, refIll);
        @(posedge clk);
        #1;
        if (rstIn) begin
            expCword   = '0;
            expIllegal = 1'b0;
            expValid   = 1'b0;
        end else if (validIn) begin
            expCword   = refCw;
            expIllegal = refIll;
            expValid   = 1'b1;
        end else begin
            expValid   = 1'b0;
        end
        checkOutput("cword", 32'(cword), 32'(expCword));
        checkOutput("illegal", 32'(illegal), 32'(expIllegal));
        checkOutput("cword_valid", 32'(cword_valid), 32'(expValid));
    endtask

    task automatic directed(input string tag, input logic [31:0] word,
                            input logic [22:0] cwExp, input logic illExp);
        applyStimulus(word, 1'b1, 1'b0);
        checkOutput({tag, "_cword"}, 32'(cword), 32'(cwExp));
        checkOutput({tag, "_illegal"}, 32'(illegal), 32'(illExp));
    endtask

    initial begin
        logic [31:0] word;
        rst        = 1'b0;
        inst       = '0;
        inst_valid = 1'b0;
        expCword   = '0;
        expIllegal = 1'b0;
        expValid   = 1'b0;
        @(negedge clk);

        applyStimulus(32'h01ea0533, 1'b1, 1'b1);
        checkOutput("reset_cword", 32'(cword), 32'h0);
        checkOutput("reset_valid", 32'(cword_valid), 32'h0);
        checkOutput("reset_illegal", 32'(illegal), 32'h0);

        directed("lh",    32'h01ea1503, 23'h028A11, 1'b0);
        directed("sh",    32'h00aa1f23, 23'h2A8013, 1'b0);
        directed("add",   32'h01ea0533, 23'h7A8A04, 1'b0);
        directed("sub",   32'h403100b3, 23'h0C4184, 1'b0);
        directed("addi",  32'h01ea0513, 23'h028A02, 1'b0);
        directed("lui",   32'h030391b7, 23'h000305, 1'b0);
        directed("auipc", 32'h0002a697, 23'h000D06, 1'b0);
        directed("bne",   32'h08419063, 23'h106017, 1'b0);
        directed("jalr",  32'h04548367, 23'h012608, 1'b0);
        directed("jal",   32'h038031ef, 23'h000309, 1'b0);
        directed("ecall", 32'h00000073, 23'h000000, 1'b1);
        directed("zero",  32'h00000000, 23'h000000, 1'b1);
        directed("lowbits", 32'h01ea0532, 23'h000000, 1'b1);
        applyStimulus(32'h41ea1533, 1'b1, 1'b0);
        checkOutput("badop_type", 32'(cword[3:0]), 32'd4);
        checkOutput("badop_illegal", 32'(illegal), 32'h1);

        directed("gate_add", 32'h01ea0533, 23'h7A8A04, 1'b0);
        checkOutput("gate_valid_hi", 32'(cword_valid), 32'h1);
        applyStimulus(32'h00000073, 1'b0, 1'b0);
        checkOutput("gate_hold_cword", 32'(cword), 32'h7A8A04);
        checkOutput("gate_valid_lo", 32'(cword_valid), 32'h0);
        checkOutput("gate_hold_illegal", 32'(illegal), 32'h0);

        for (int n = 0; n < 400; n++) begin
            word = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                word[6:0] = opcodeTable[$urandom_range(0, 8)];
                if ($urandom_range(0, 1) == 1) word[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            applyStimulus(word, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
